serial_addsub_32bit: RTL

Multi-cycle 32-bit unsigned/two's-complement adder-subtractor. It processes operands one DIGIT_W-bit slice per clock, LSB slice first, behind a start/done handshake. It is the sequential counterpart of the combinational 32-bit CLA: the same a/b/ci operand set, plus the subtract direction and borrow-out. It sits in the datapath test area, where area-lean arithmetic and multi-cycle handshake behaviour are exercised against the single-cycle adder results.

---
 rtl/serial_addsub_32bit_if.sv | 24 ++
 rtl/serial_addsub_32bit.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_addsub_32bit_if.sv
// Handshake and operand/result bundle for the serial adder-subtractor.
// The master side issues start/operands; the slave side returns status and results.
interface serial_addsub_32bit_if;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        co;
    logic        ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, result, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, result, co, ovf
    );
endinterface

// File: rtl/serial_addsub_32bit.sv
// Multi-cycle 32-bit adder-subtractor: one DIGIT_W-bit slice per clock, LSB slice first,
// with start/done handshake and results that only update on completion.
module serial_addsub_32bit #(
    parameter int unsigned DIGIT_W = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    serial_addsub_32bit_if.slave  bus
);

    localparam int unsigned STEPS = 32 / DIGIT_W;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        shadow_q;
    logic               carry_q;
    logic               sub_q;
    logic               busy_q;
    logic               done_q;
    logic [31:0]        result_q;
    logic               co_q;
    logic               ovf_q;

    logic [5:0]         slice_lo;
    logic [DIGIT_W-1:0] a_slice;
    logic [DIGIT_W-1:0] b_slice;
    logic [DIGIT_W:0]   slice_sum;
    logic [31:0]        shadow_next;

    // Current slice datapath; shadow_next is the full word once the last slice lands.
    always_comb begin
        slice_lo    = 6'(cnt_q) * 6'(DIGIT_W);
        a_slice     = a_q[slice_lo +: DIGIT_W];
        b_slice     = b_q[slice_lo +: DIGIT_W];
        slice_sum   = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT_W{1'b0}}, carry_q};
        shadow_next = shadow_q;
        shadow_next[slice_lo +: DIGIT_W] = slice_sum[DIGIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        // Subtract as a + ~b + ~ci, so borrow-out is the inverted carry.
                        a_q      <= bus.a;
                        b_q      <= bus.sub ? ~bus.b : bus.b;
                        carry_q  <= bus.sub ? ~bus.ci : bus.ci;
                        sub_q    <= bus.sub;
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    shadow_q <= shadow_next;
                    carry_q  <= slice_sum[DIGIT_W];
                    if (cnt_q == LAST) begin
                        result_q <= shadow_next;
                        co_q     <= sub_q ^ slice_sum[DIGIT_W];
                        ovf_q    <= (a_q[31] == b_q[31]) && (shadow_next[31] != a_q[31]);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.co     = co_q;
    assign bus.ovf    = ovf_q;

endmodule
